// File: rtl/card_round_judge.sv
// N-player card round controller: deals pile-top and player cards, judges the
// keypad answer against the card match, keeps saturating scores and detects a winner.
module card_round_judge #(
    parameter int NUM_PLAYERS    = 2,
    parameter int SCORE_W        = 4,
    parameter int WIN_SCORE      = 5,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int SHOW_CYCLES    = 50,
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           start_i,
    input  logic                           key_valid_i,
    input  logic [3:0]                     key_code_i,
    input  logic [4:0]                     rnd_i,
    output logic                           rnd_en_o,
    output logic [1:0]                     card_color_o,
    output logic [2:0]                     card_number_o,
    output logic [1:0]                     top_color_o,
    output logic [2:0]                     top_number_o,
    output logic [PW-1:0]                  cur_player_o,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores_o,
    output logic                           result_valid_o,
    output logic                           result_right_o,
    output logic                           game_over_o,
    output logic [PW-1:0]                  winner_o
);

    // state    | meaning
    // IDLE     | after reset, waiting for start
    // DEAL_TOP | pile-top card taken from rnd
    // DRAW     | current player's card taken from rnd
    // WAIT_KEY | waiting for an answer or the timeout
    // SHOW     | judgement displayed for SHOW_CYCLES cycles
    // OVER     | winner found, waiting for start
    typedef enum logic [2:0] {
        S_IDLE, S_DEAL_TOP, S_DRAW, S_WAIT_KEY, S_SHOW, S_OVER
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int CW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t                         state_q;
    logic [TW-1:0]                  tmo_cnt_q;
    logic [CW-1:0]                  show_cnt_q;
    logic                           rnd_en_q;
    logic [1:0]                     card_color_q;
    logic [2:0]                     card_number_q;
    logic [1:0]                     top_color_q;
    logic [2:0]                     top_number_q;
    logic [PW-1:0]                  cur_player_q;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores_q;
    logic                           result_valid_q;
    logic                           result_right_q;
    logic                           game_over_q;
    logic [PW-1:0]                  winner_q;

    logic [1:0]         expected_code;
    logic               key_ok;
    logic               answer_right;
    logic               timeout;
    logic [SCORE_W-1:0] cur_score;
    logic [SCORE_W-1:0] score_d;
    logic [PW-1:0]      cur_player_d;

    assign expected_code = {card_number_q == top_number_q, card_color_q == top_color_q};
    assign key_ok        = key_valid_i && (key_code_i <= 4'd3);
    assign answer_right  = key_ok && (key_code_i[1:0] == expected_code);
    assign timeout       = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign cur_player_d  = (cur_player_q == PW'(NUM_PLAYERS - 1)) ? '0 : cur_player_q + PW'(1);

    always_comb begin
        cur_score = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (cur_player_q == PW'(i)) begin
                cur_score = scores_q[i*SCORE_W +: SCORE_W];
            end
        end
    end

    // Timeout judges as wrong, so answer_right alone picks the direction.
    always_comb begin
        score_d = cur_score;
        if (answer_right) begin
            if (cur_score != SCORE_MAX) score_d = cur_score + SCORE_W'(1);
        end else begin
            if (cur_score != '0) score_d = cur_score - SCORE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= S_IDLE;
            tmo_cnt_q      <= '0;
            show_cnt_q     <= '0;
            rnd_en_q       <= 1'b0;
            card_color_q   <= '0;
            card_number_q  <= '0;
            top_color_q    <= '0;
            top_number_q   <= '0;
            cur_player_q   <= '0;
            scores_q       <= '0;
            result_valid_q <= 1'b0;
            result_right_q <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start_i) begin
                        scores_q     <= '0;
                        cur_player_q <= '0;
                        winner_q     <= '0;
                        game_over_q  <= 1'b0;
                        rnd_en_q     <= 1'b1;
                        state_q      <= S_DEAL_TOP;
                    end
                end
                S_DEAL_TOP: begin
                    top_color_q  <= rnd_i[4:3];
                    top_number_q <= rnd_i[2:0];
                    state_q      <= S_DRAW;
                end
                S_DRAW: begin
                    card_color_q  <= rnd_i[4:3];
                    card_number_q <= rnd_i[2:0];
                    tmo_cnt_q     <= '0;
                    rnd_en_q      <= 1'b0;
                    state_q       <= S_WAIT_KEY;
                end
                S_WAIT_KEY: begin
                    if (key_ok || timeout) begin
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (cur_player_q == PW'(i)) begin
                                scores_q[i*SCORE_W +: SCORE_W] <= score_d;
                            end
                        end
                        result_right_q <= answer_right;
                        result_valid_q <= 1'b1;
                        show_cnt_q     <= CW'(SHOW_CYCLES - 1);
                        state_q        <= S_SHOW;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TW'(1);
                    end
                end
                S_SHOW: begin
                    if (show_cnt_q == '0) begin
                        result_valid_q <= 1'b0;
                        if (cur_score >= SCORE_W'(WIN_SCORE)) begin
                            winner_q    <= cur_player_q;
                            game_over_q <= 1'b1;
                            state_q     <= S_OVER;
                        end else begin
                            top_color_q  <= card_color_q;
                            top_number_q <= card_number_q;
                            cur_player_q <= cur_player_d;
                            rnd_en_q     <= 1'b1;
                            state_q      <= S_DRAW;
                        end
                    end else begin
                        show_cnt_q <= show_cnt_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rnd_en_o       = rnd_en_q;
    assign card_color_o   = card_color_q;
    assign card_number_o  = card_number_q;
    assign top_color_o    = top_color_q;
    assign top_number_o   = top_number_q;
    assign cur_player_o   = cur_player_q;
    assign scores_o       = scores_q;
    assign result_valid_o = result_valid_q;
    assign result_right_o = result_right_q;
    assign game_over_o    = game_over_q;
    assign winner_o       = winner_q;

endmodule
